// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and constants for the FIFO stream reader
package fifo_pkg;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} rd_buf_state_t;

  localparam int C_BUF_DEPTH = 2;

  function automatic logic [1:0] occ_of(input rd_buf_state_t s);
    case (s)
      S_ONE:   return 2'd1;
      S_TWO:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - FIFO read port plus outgoing valid/ready stream
interface fifo_stream_reader_if #(
  parameter int G_WIDTH = 8
);
  logic               fifo_rd;
  logic               fifo_empty;
  logic [G_WIDTH-1:0] fifo_data;
  logic               fifo_rd_done;
  logic               valid;
  logic               ready;
  logic [G_WIDTH-1:0] data;

  modport master (
    output fifo_rd,
    input  fifo_empty,
    input  fifo_data,
    input  fifo_rd_done,
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  fifo_rd,
    output fifo_empty,
    output fifo_data,
    output fifo_rd_done,
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/stream_buf2.sv
// rtl/stream_buf2.sv - two-entry ordered buffer; head is always the oldest word
module stream_buf2
  import fifo_pkg::*;
#(
  parameter int G_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [G_WIDTH-1:0] wdata,
  output logic [G_WIDTH-1:0] head,
  output logic [1:0]         occ,
  output logic               overrun
);

  rd_buf_state_t      state;
  logic [G_WIDTH-1:0] entry0;
  logic [G_WIDTH-1:0] entry1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_EMPTY;
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (push) begin
            entry0 <= wdata;
            state  <= S_ONE;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            entry0 <= wdata;
          end else if (push) begin
            entry1 <= wdata;
            state  <= S_TWO;
          end else if (pop) begin
            state <= S_EMPTY;
          end
        end
        S_TWO: begin
          // a push without a pop here is an overrun: the word is dropped
          if (push && pop) begin
            entry0 <= entry1;
            entry1 <= wdata;
          end else if (pop) begin
            entry0 <= entry1;
            state  <= S_ONE;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  assign head    = entry0;
  assign occ     = occ_of(state);
  assign overrun = push && !pop && (state == S_TWO);

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-side master feeding a valid/ready stream; FIFO_READER_STATS_EN adds word/stall counters
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int G_WIDTH = 8
`ifdef FIFO_READER_STATS_EN
  ,
  parameter int G_CNT_W = 16
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  fifo_stream_reader_if.master bus,
  output logic                 o_err
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [G_CNT_W-1:0]   o_words,
  output logic [G_CNT_W-1:0]   o_stalls
`endif
);

  logic               inflight;
  logic               pop;
  logic               push;
  logic               overrun;
  logic [1:0]         occ;
  logic [2:0]         credit_use;
  logic [G_WIDTH-1:0] head;

  stream_buf2 #(.G_WIDTH(G_WIDTH)) u_buf (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .push    (push),
    .pop     (pop),
    .wdata   (bus.fifo_data),
    .head    (head),
    .occ     (occ),
    .overrun (overrun)
  );

  assign bus.valid = (occ != 2'd0);
  assign bus.data  = head;
  assign pop       = bus.valid && bus.ready;
  assign push      = bus.fifo_rd_done && inflight;

  // Counting the current pop as freed space keeps a full buffer streaming at one word per cycle.
  assign credit_use  = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign bus.fifo_rd = i_rst_n && !bus.fifo_empty && (credit_use < 3'(C_BUF_DEPTH));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      inflight <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      inflight <= bus.fifo_rd;
      if ((bus.fifo_rd_done && !inflight) || overrun) begin
        o_err <= 1'b1;
      end
    end
  end

`ifdef FIFO_READER_STATS_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_words  <= '0;
      o_stalls <= '0;
    end else begin
      if (pop) begin
        o_words <= o_words + 1'b1;
      end
      if (bus.valid && !bus.ready) begin
        o_stalls <= o_stalls + 1'b1;
      end
    end
  end
`endif

endmodule
